fir_mac_sequencer: RTL
======================

# fir_mac_sequencer

Time-multiplexed controller for the 19-tap symmetric binary FIR. It replaces the fully parallel tap array with one pre-adder/multiplier/accumulator, which it sequences over the 10 unique coefficients. It owns the 19-sample delay line and sits between the sample source and the FIR result consumer, using valid/ready handshakes on both sides. Its output is bit-exact to the combinational filter: an unsigned sum modulo 2^DATA_W.

## Interface
- DATA_W, 13: sample and result width.
- COEF_W, 12: coefficient width.
- TAPS, 19: filter length. Must be odd. HALF = (TAPS-1)/2 = 9.
- clock  in  1  sampling/system clock, rising edge.
- reset  in  1  asynchronous, active-high. Clears all state.
- in_valid  in  1  sample offered.
- in_ready  out  1  high only in IDLE while flush = 0.
- in_data  in  DATA_W  new sample, taken when in_valid & in_ready.
- flush  in  1  clears the delay line. Honoured in IDLE only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  filter result, stable while out_valid.
- busy  out  1  high when state != IDLE.

## Operation
- States:
  - IDLE: accept edge -> MAC with idx=0, acc=0, and the delay line shifts (d[0] <= in_data, d[k] <= d[k-1]).
  - MAC, one accumulation per cycle:
    - idx 0..8: acc += c[idx]*(d[idx]+d[18-idx]).
    - idx 9: acc += c[9]*d[9], then out_data <= acc, go to DONE.
  - DONE: out_valid=1 and out_data held until out_ready=1. That edge -> IDLE.
- Arithmetic: unsigned throughout. The pre-add, product and accumulate are each truncated to DATA_W bits (mod 8192). No saturation, no rounding.
- Default coefficients c[0..9] = 3, 0, 4075, 0, 78, 0, 3859, 0, 943, 1533. The filter is symmetric, so c[18-i] = c[i].
- Flush in IDLE clears d[0..18] to 0. If flush and in_valid arrive together, flush wins and no sample is accepted.
- Flush outside IDLE is ignored.
- in_valid outside IDLE is not accepted. in_ready is low there.

## Timing
- Reset values:
  - state IDLE, d[*]=0, acc=0, idx=0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=1 after reset deasserts (combinational from IDLE & !flush).
- Latency: sample accepted at edge E0 -> out_valid visible after edge E10.
- Minimum initiation interval: 12 cycles (E0 accept, E1..E10 MAC, E11 handshake out if out_ready=1, next accept at E12).
- out_ready held low: the block stalls in DONE indefinitely. out_data does not change.
- Reset asserted mid-MAC or in DONE: immediate return to reset values. The partial result is discarded and the delay line is cleared.
- out_valid and out_data are registered. in_ready and busy are combinational from state and flush only.

## Configuration
- FIR_COEF_LOAD_EN defined:
  - Adds ports coef_we (in, 1), coef_addr (in, 4), coef_wdata (in, COEF_W).
  - Coefficients live in a 10-entry register file, reset to the default set.
  - A write is accepted only in IDLE when coef_addr <= 9. Other writes are silently ignored.
  - A write and a sample accept in the same IDLE cycle are both performed. The new coefficient is used for that sample.
- FIR_COEF_LOAD_EN undefined: no extra ports. Coefficients are constants from the package.

## Structure
- Package fir_pkg holds:
  - DATA_W, COEF_W, TAPS, HALF.
  - The default coefficient array localparam.
  - The state enum typedef (IDLE, MAC, DONE).
- Sub-module fir_pair_mac: combinational pre-adder plus multiplier plus accumulate-register update. Inputs a, b, coef, acc_in, center_sel; output acc_next. Each operation is truncated to DATA_W.
- The top level holds the FSM, delay line, idx counter, handshake logic and optional coefficient register file.

## Test plan
- Impulse: after reset, send 1 followed by 18 zeros, out_ready=1 -> outputs are 3, 0, 4075, 0, 78, 0, 3859, 0, 943, 1533, 943, 0, 3859, 0, 78, 0, 4075, 0, 3. Each out_valid appears exactly 10 cycles after its accept edge.
- Step: send 19 consecutive samples of 1 -> 19th output = 3065 (19449 mod 8192).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_data constant throughout, in_ready=0, busy=1. Release -> IDLE the next cycle.
- Reset mid-MAC: assert reset at idx=4 -> out_valid=0, out_data=0, busy=0 immediately. A subsequent impulse yields 3 as its first output.
- Flush: load 19 ones, flush in IDLE with in_valid=1 -> no sample accepted that cycle. The next sample 0 yields 0.
- Coefficient load (FIR_COEF_LOAD_EN): write addr 0 = 10 and addr 12 = 99, then send an impulse:
  - first and 19th outputs = 10;
  - other outputs unchanged from the impulse test;
  - the addr 12 write has no effect.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, default coefficient set and FSM state type for the FIR MAC sequencer.
// No logic lives here.
// No handshake; pure definitions.
package fir_pkg;

    localparam int DATA_W = 13;
    localparam int COEF_W = 12;
    localparam int TAPS   = 19;
    localparam int HALF   = (TAPS - 1) / 2;

    // Unique coefficients c[0..HALF]; element 0 is the rightmost entry.
    localparam logic [HALF:0][COEF_W-1:0] DEFAULT_COEF = {
        12'd1533, 12'd943, 12'd0, 12'd3859, 12'd0,
        12'd78,   12'd0,   12'd4075, 12'd0, 12'd3
    };

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_e;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / result-out handshake bundle for the FIR MAC sequencer (optional coefficient
// write port under FIR_COEF_LOAD_EN).
// master = sample source and result consumer side; slave = the sequencer.
interface fir_mac_sequencer_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [fir_pkg::DATA_W-1:0]  in_data;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [fir_pkg::DATA_W-1:0]  out_data;
    logic                        busy;
`ifdef FIR_COEF_LOAD_EN
    logic                        coef_we;
    logic [3:0]                  coef_addr;
    logic [fir_pkg::COEF_W-1:0]  coef_wdata;
`endif

    modport master (
        output in_valid, in_data, flush, out_ready,
`ifdef FIR_COEF_LOAD_EN
        output coef_we, coef_addr, coef_wdata,
`endif
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
`ifdef FIR_COEF_LOAD_EN
        input  coef_we, coef_addr, coef_wdata,
`endif
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/fir_pair_mac.sv
// One symmetric-pair step: pre-add, multiply by coefficient, accumulate (all mod 2^DATA_W).
// Latency: purely combinational.
// Backpressure: none; the caller registers acc_next.
module fir_pair_mac
    import fir_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [COEF_W-1:0] coef,
    input  logic [DATA_W-1:0] acc_in,
    input  logic              center_sel,
    output logic [DATA_W-1:0] acc_next
);

    logic [DATA_W-1:0]        pre_sum;
    logic [DATA_W+COEF_W-1:0] prod_full;

    // Center tap has no partner sample, so it bypasses the pre-adder.
    always_comb begin
        pre_sum   = center_sel ? a : a + b;
        prod_full = {{DATA_W{1'b0}}, coef} * {{COEF_W{1'b0}}, pre_sum};
        acc_next  = acc_in + prod_full[DATA_W-1:0];
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// 19-tap symmetric FIR computed with one pair-MAC over 10 cycles; FIR_COEF_LOAD_EN adds a coefficient file.
// Latency: sample accepted at E0, out_valid after E10; initiation interval 12 cycles.
// Backpressure: in_ready only in IDLE without flush; result held in DONE until out_ready.
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    fir_mac_sequencer_if.slave   bus
);

    localparam logic [3:0] IDX_LAST = 4'(HALF);
    localparam logic [4:0] TAP_LAST = 5'(TAPS - 1);

    state_e              state_q;
    logic [3:0]          idx_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   acc_d;
    logic                out_vld_q;
    logic [DATA_W-1:0]   out_dat_q;
    logic [DATA_W-1:0]   dline_q [TAPS];
    logic [COEF_W-1:0]   coef_cur;
    logic [4:0]          lo_idx;
    logic [4:0]          hi_idx;
    logic                accept;
    logic                idle;

    assign idle         = (state_q == IDLE);
    assign bus.in_ready = idle && !bus.flush;
    assign bus.busy     = !idle;
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_dat_q;

    assign lo_idx = {1'b0, idx_q};
    assign hi_idx = TAP_LAST - lo_idx;

`ifdef FIR_COEF_LOAD_EN
    logic [COEF_W-1:0] coef_q [HALF+1];

    // Coefficient file: writes land only while idle and only for valid addresses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= HALF; k++) coef_q[k] <= DEFAULT_COEF[k];
        end else if (idle && bus.coef_we && (bus.coef_addr <= IDX_LAST)) begin
            coef_q[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    assign coef_cur = coef_q[idx_q];
`else
    assign coef_cur = DEFAULT_COEF[idx_q];
`endif

    fir_pair_mac u_pair_mac (
        .a          (dline_q[lo_idx]),
        .b          (dline_q[hi_idx]),
        .coef       (coef_cur),
        .acc_in     (acc_q),
        .center_sel (idx_q == IDX_LAST),
        .acc_next   (acc_d)
    );

    // Delay line: flush clears it in IDLE (flush beats a sample), an accept shifts it in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) dline_q[k] <= '0;
        end else if (idle && bus.flush) begin
            for (int k = 0; k < TAPS; k++) dline_q[k] <= '0;
        end else if (accept) begin
            dline_q[0] <= bus.in_data;
            for (int k = 1; k < TAPS; k++) dline_q[k] <= dline_q[k-1];
        end
    end

    // Sequencer FSM: accept, ten accumulation steps, then hold the result until taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= MAC;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == IDX_LAST) begin
                        out_dat_q <= acc_d;
                        out_vld_q <= 1'b1;
                        idx_q     <= '0;
                        state_q   <= DONE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
